// File: rtl/lmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lmem_pkg
//  Description : Shared types, constants and lane helpers for the banked
//                local-memory request sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lmem_pkg;

    // Width of one memory bank lane; four lanes make one 128-bit row.
    localparam int unsigned LANE_W = 32;

    // Command opcodes. Encodings 6 and 7 are illegal.
    typedef enum logic [2:0] {
        OP_LD_S  = 3'd0,
        OP_ST_S  = 3'd1,
        OP_LD_V  = 3'd2,
        OP_ST_V  = 3'd3,
        OP_LD_VS = 3'd4,
        OP_ST_VS = 3'd5
    } op_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    // Every legal store has an odd encoding.
    function automatic logic op_is_store(input logic [2:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_vector(input logic [2:0] op);
        return (op == OP_LD_V) || (op == OP_ST_V);
    endfunction

    function automatic logic op_is_strided(input logic [2:0] op);
        return (op == OP_LD_VS) || (op == OP_ST_VS);
    endfunction

    // Alignment rules: vector rows need 16-byte alignment, everything else
    // needs word alignment of the address and (for strided ops) the stride.
    function automatic logic cmd_misaligned(input logic [2:0] op,
                                            input logic [3:0] addr_lo,
                                            input logic [1:0] stride_lo);
        logic r;
        case (op)
            OP_LD_V, OP_ST_V:   r = (addr_lo != 4'd0);
            OP_LD_VS, OP_ST_VS: r = (addr_lo[1:0] != 2'd0) || (stride_lo != 2'd0);
            default:            r = (addr_lo[1:0] != 2'd0);
        endcase
        return r;
    endfunction

    // Pick one 32-bit lane out of a 128-bit row.
    function automatic logic [LANE_W-1:0] lane_get(input logic [4*LANE_W-1:0] data,
                                                   input logic [1:0]          idx);
        logic [LANE_W-1:0] r;
        case (idx)
            2'd0:    r = data[0*LANE_W +: LANE_W];
            2'd1:    r = data[1*LANE_W +: LANE_W];
            2'd2:    r = data[2*LANE_W +: LANE_W];
            default: r = data[3*LANE_W +: LANE_W];
        endcase
        return r;
    endfunction

    // Replace one 32-bit lane of a 128-bit row.
    function automatic logic [4*LANE_W-1:0] lane_put(input logic [4*LANE_W-1:0] data,
                                                     input logic [1:0]          idx,
                                                     input logic [LANE_W-1:0]   val);
        logic [4*LANE_W-1:0] r;
        r = data;
        case (idx)
            2'd0:    r[0*LANE_W +: LANE_W] = val;
            2'd1:    r[1*LANE_W +: LANE_W] = val;
            2'd2:    r[2*LANE_W +: LANE_W] = val;
            default: r[3*LANE_W +: LANE_W] = val;
        endcase
        return r;
    endfunction

endpackage : lmem_pkg
`default_nettype wire

// File: rtl/lmem_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lmem_req_sequencer
//  Description : Turns scalar, vector and 4-beat strided load/store commands
//                into beats on a banked local-memory port, gathers load data
//                and returns a single tagged response per command.
//  Revision    : 1.0 - initial release
// ============================================================================
module lmem_req_sequencer
    import lmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [31:0]   cmd_addr,
    input  logic [31:0]   cmd_stride,
    input  logic [127:0]  cmd_wdata,
    input  logic [3:0]    cmd_tag,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [127:0]  rsp_rdata,
    output logic [3:0]    rsp_tag,
    output logic          rsp_err,

    output logic          mem_req_valid,
    output logic          mem_req_we,
    output logic          mem_req_is_vector,
    output logic [1:0]    mem_req_bank_sel,
    output logic [31:0]   mem_req_addr,
    output logic [127:0]  mem_req_wdata,
    input  logic [127:0]  mem_resp_rdata
);

    localparam logic [31:0] c_DEPTH = 32'(DEPTH_WORDS);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e          r_state;
    logic [2:0]      r_op;
    logic [31:0]     r_baddr;      // address of the beat currently issuing
    logic [31:0]     r_stride;
    logic [127:0]    r_wdata;
    logic [3:0]      r_tag;
    logic [1:0]      r_k;          // beat counter
    logic            r_err;
    logic [127:0]    r_rdata;
    logic            r_cap_valid;  // a load beat was issued last cycle
    logic [1:0]      r_cap_k;      // its beat number
    logic [1:0]      r_cap_bank;   // its bank lane

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    state_e          w_state_nxt;
    logic            w_cmd_bad;
    logic            w_in_range;
    logic            w_is_load;
    logic            w_last_beat;
    logic [31:0]     w_store_lane;
    logic [31:0]     w_bank_word;
    logic [127:0]    w_rdata_nxt;

    assign w_cmd_bad    = !op_legal(cmd_op) ||
                          cmd_misaligned(cmd_op, cmd_addr[3:0], cmd_stride[1:0]);
    // The range check is applied to the (possibly wrapped) beat address.
    assign w_in_range   = ({4'd0, r_baddr[31:4]} < c_DEPTH);
    assign w_is_load    = !op_is_store(r_op);
    assign w_last_beat  = !op_is_strided(r_op) || (r_k == 2'd3);
    // Scalar stores use lane 0 (k is always 0); strided stores use lane k.
    assign w_store_lane = lane_get(r_wdata, r_k);

    assign rsp_rdata = r_rdata;
    assign rsp_tag   = r_tag;
    assign rsp_err   = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: bad commands skip straight to the response, loads
    // spend one extra cycle draining the final read beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = w_cmd_bad ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_last_beat) begin
                    w_state_nxt = w_is_load ? ST_DRAIN : ST_RESP;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshakes and the memory beat are pure functions of state.
    always_comb begin
        cmd_ready         = 1'b0;
        rsp_valid         = 1'b0;
        mem_req_valid     = 1'b0;
        mem_req_we        = 1'b0;
        mem_req_is_vector = 1'b0;
        mem_req_bank_sel  = 2'd0;
        mem_req_addr      = 32'd0;
        mem_req_wdata     = 128'd0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_ISSUE: begin
                // Out-of-range beats still consume their slot but are not sent.
                mem_req_valid     = w_in_range;
                mem_req_we        = op_is_store(r_op);
                mem_req_is_vector = op_is_vector(r_op);
                mem_req_bank_sel  = r_baddr[3:2];
                mem_req_addr      = {2'b00, r_baddr[31:4], 2'b00};
                if (op_is_vector(r_op)) begin
                    mem_req_wdata = r_wdata;
                end else if (op_is_store(r_op)) begin
                    mem_req_wdata = {96'd0, w_store_lane};
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Merge the read data of the beat issued last cycle into the response.
    always_comb begin
        w_bank_word = lane_get(mem_resp_rdata, r_cap_bank);
        case (r_op)
            OP_LD_V:  w_rdata_nxt = mem_resp_rdata;
            OP_LD_VS: w_rdata_nxt = lane_put(r_rdata, r_cap_k, w_bank_word);
            default:  w_rdata_nxt = {96'd0, w_bank_word};
        endcase
    end

    // Command latch, beat sequencing and load-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 3'd0;
            r_baddr     <= 32'd0;
            r_stride    <= 32'd0;
            r_wdata     <= 128'd0;
            r_tag       <= 4'd0;
            r_k         <= 2'd0;
            r_err       <= 1'b0;
            r_rdata     <= 128'd0;
            r_cap_valid <= 1'b0;
            r_cap_k     <= 2'd0;
            r_cap_bank  <= 2'd0;
        end else begin
            // Read data arrives one cycle after its beat, so beat k-1 lands
            // while beat k is issuing and the last beat lands in DRAIN.
            if (r_cap_valid) begin
                r_rdata <= w_rdata_nxt;
            end
            r_cap_valid <= (r_state == ST_ISSUE) && w_in_range && w_is_load;
            r_cap_k     <= r_k;
            r_cap_bank  <= r_baddr[3:2];

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op     <= cmd_op;
                        r_baddr  <= cmd_addr;
                        r_stride <= cmd_stride;
                        r_wdata  <= cmd_wdata;
                        r_tag    <= cmd_tag;
                        r_k      <= 2'd0;
                        r_err    <= w_cmd_bad;
                        r_rdata  <= 128'd0;
                    end
                end
                ST_ISSUE: begin
                    // Accumulating the stride wraps naturally modulo 2^32.
                    r_k     <= r_k + 2'd1;
                    r_baddr <= r_baddr + r_stride;
                    if (!w_in_range) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : lmem_req_sequencer
`default_nettype wire

// File: tb/tb_lmem_req_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lmem_req_sequencer
//  Description : Self-checking bench: directed vector table, randomized
//                commands against a word-array reference model, and a
//                reset-during-operation sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lmem_req_sequencer;
    import lmem_pkg::*;

    localparam int D = 16;   // small memory so the range boundary is easy to hit

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_stride;
    logic [127:0]  cmd_wdata;
    logic [3:0]    cmd_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [127:0]  rsp_rdata;
    logic [3:0]    rsp_tag;
    logic          rsp_err;
    logic          mem_req_valid;
    logic          mem_req_we;
    logic          mem_req_is_vector;
    logic [1:0]    mem_req_bank_sel;
    logic [31:0]   mem_req_addr;
    logic [127:0]  mem_req_wdata;
    logic [127:0]  mem_resp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lmem_req_sequencer #(.DEPTH_WORDS(D)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_addr          (cmd_addr),
        .cmd_stride        (cmd_stride),
        .cmd_wdata         (cmd_wdata),
        .cmd_tag           (cmd_tag),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_tag           (rsp_tag),
        .rsp_err           (rsp_err),
        .mem_req_valid     (mem_req_valid),
        .mem_req_we        (mem_req_we),
        .mem_req_is_vector (mem_req_is_vector),
        .mem_req_bank_sel  (mem_req_bank_sel),
        .mem_req_addr      (mem_req_addr),
        .mem_req_wdata     (mem_req_wdata),
        .mem_resp_rdata    (mem_resp_rdata)
    );

    // Banked memory: rows of four 32-bit lanes, registered read data.
    logic [127:0] mem_rows [D];
    logic         mem_clear;
    int           bad_req = 0;
    int           row_i;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < D; i++) mem_rows[i] <= 128'd0;
            mem_resp_rdata <= 128'd0;
        end else if (mem_req_valid) begin
            row_i = int'(mem_req_addr[31:2]);
            if (mem_req_addr[1:0] != 2'd0 || row_i >= D) begin
                bad_req <= bad_req + 1;
            end else if (mem_req_we) begin
                if (mem_req_is_vector) mem_rows[row_i] <= mem_req_wdata;
                else mem_rows[row_i][32*mem_req_bank_sel +: 32] <= mem_req_wdata[31:0];
            end else begin
                mem_resp_rdata <= mem_rows[row_i];
            end
        end
    end

    // Reference memory as a flat array of 32-bit words (word index = A/4).
    logic [31:0] ref_mem [D*4];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Behavioural model of one command; applies stores to ref_mem.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] stride,
                         input logic [127:0] wdata,
                         output logic [127:0] rd, output logic err, output int lat,
                         output int issued, output logic [31:0] faddr, output logic [1:0] fbank);
        logic [31:0] a;
        int nb, w;
        bit st, vec, strd;
        rd = '0; err = 1'b0; issued = 0; faddr = '0; fbank = '0; lat = 1;
        st   = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
        vec  = (op == 3'd2) || (op == 3'd3);
        strd = (op == 3'd4) || (op == 3'd5);
        if (op > 3'd5) begin err = 1'b1; return; end
        if ((vec && addr % 16 != 0) || (addr % 4 != 0) || (strd && stride % 4 != 0)) begin
            err = 1'b1; return;
        end
        nb  = strd ? 4 : 1;
        lat = st ? nb + 1 : nb + 2;
        for (int k = 0; k < nb; k++) begin
            a = addr + stride * 32'(k);
            if ((a >> 4) >= 32'(D)) begin err = 1'b1; continue; end
            if (issued == 0) begin faddr = (a >> 4) << 2; fbank = a[3:2]; end
            issued++;
            w = int'(a >> 2);
            case (op)
                3'd0: rd[31:0] = ref_mem[w];
                3'd1: ref_mem[w] = wdata[31:0];
                3'd2: for (int i = 0; i < 4; i++) rd[32*i +: 32] = ref_mem[w+i];
                3'd3: for (int i = 0; i < 4; i++) ref_mem[w+i] = wdata[32*i +: 32];
                3'd4: rd[32*k +: 32] = ref_mem[w];
                default: ref_mem[w] = wdata[32*k +: 32];
            endcase
        end
    endtask

    // Issue one command (called at #1 after an edge with the DUT idle) and
    // check latency, beat count, first beat placement, response and handshake.
    task automatic run_cmd(input string nm, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] stride, input logic [127:0] wdata,
                           input logic [3:0] tag, input int hold,
                           input logic [127:0] e_rd, input logic e_err, input int e_lat,
                           input int e_beats, input logic [31:0] e_fa, input logic [1:0] e_fb);
        int cyc, beats;
        bit got;
        logic [31:0] fa;
        logic [1:0]  fb;
        check({nm, ".cmd_ready"}, 128'(cmd_ready), 128'(1'b1));
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_stride = stride;
        cmd_wdata = wdata; cmd_tag = tag; rsp_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_addr = $urandom; cmd_stride = $urandom;
        cmd_wdata = {$urandom, $urandom, $urandom, $urandom}; cmd_tag = 4'($urandom);
        cyc = 1; beats = 0; got = 1'b0; fa = '0; fb = '0;
        while (cyc <= 12) begin
            if (rsp_valid) begin got = 1'b1; break; end
            if (mem_req_valid) begin
                if (beats == 0) begin fa = mem_req_addr; fb = mem_req_bank_sel; end
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, ".latency"}, 128'(got ? cyc : -1), 128'(e_lat));
        if (!got) return;
        check({nm, ".beats"}, 128'(beats), 128'(e_beats));
        if (e_beats > 0) begin
            check({nm, ".mem_addr"}, 128'(fa), 128'(e_fa));
            check({nm, ".bank_sel"}, 128'(fb), 128'(e_fb));
        end
        check({nm, ".rdata"}, rsp_rdata, e_rd);
        check({nm, ".err"}, 128'(rsp_err), 128'(e_err));
        check({nm, ".tag"}, 128'(rsp_tag), 128'(tag));
        check({nm, ".req_in_resp"}, 128'(mem_req_valid), 128'(1'b0));
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
            check({nm, ".hold_valid"}, 128'(rsp_valid), 128'(1'b1));
            check({nm, ".hold_rdata"}, rsp_rdata, e_rd);
            check({nm, ".hold_tag_err"}, 128'({rsp_tag, rsp_err}), 128'({tag, e_err}));
            check({nm, ".hold_cmd_ready"}, 128'(cmd_ready), 128'(1'b0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, ".after_rsp_valid"}, 128'(rsp_valid), 128'(1'b0));
        check({nm, ".after_cmd_ready"}, 128'(cmd_ready), 128'(1'b1));
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [31:0]  addr;
        logic [31:0]  stride;
        logic [127:0] wdata;
        logic [3:0]   tag;
        int           hold;
        logic [127:0] exp_rdata;
        logic         exp_err;
        int           exp_lat;
        int           exp_beats;
        logic [31:0]  exp_fa;
        logic [1:0]   exp_fb;
    } vec_t;

    vec_t tbl [15];

    // Main stimulus.
    initial begin
        logic [127:0] m_rd;
        logic         m_err;
        int           m_lat, m_beats;
        logic [31:0]  m_fa, m_stride, m_addr;
        logic [1:0]   m_fb;
        logic [2:0]   m_op;
        logic [127:0] m_wd;
        bit           seen_req, seen_rsp;

        tbl[0]  = '{3'd1, 32'h24, 32'd0, 128'hDEADBEEF, 4'd1, 0, 128'd0, 1'b0, 2, 1, 32'h8, 2'd1};
        tbl[1]  = '{3'd0, 32'h24, 32'd0, 128'd0, 4'd2, 0, 128'hDEADBEEF, 1'b0, 3, 1, 32'h8, 2'd1};
        tbl[2]  = '{3'd3, 32'h40, 32'd0, 128'h44444444_33333333_22222222_11111111, 4'd3, 0,
                    128'd0, 1'b0, 2, 1, 32'h10, 2'd0};
        tbl[3]  = '{3'd4, 32'h40, 32'd4, 128'd0, 4'd4, 0,
                    128'h44444444_33333333_22222222_11111111, 1'b0, 6, 4, 32'h10, 2'd0};
        tbl[4]  = '{3'd2, 32'h44, 32'd0, 128'd0, 4'd5, 0, 128'd0, 1'b1, 1, 0, 32'h0, 2'd0};
        tbl[5]  = '{3'd5, 32'hF8, 32'd4, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4'd6, 0,
                    128'd0, 1'b1, 5, 2, 32'h3C, 2'd2};
        tbl[6]  = '{3'd4, 32'hF8, 32'd4, 128'd0, 4'd7, 0,
                    128'h00000000_00000000_BBBBBBBB_AAAAAAAA, 1'b1, 6, 2, 32'h3C, 2'd2};
        tbl[7]  = '{3'd6, 32'h0, 32'd0, 128'd0, 4'd8, 0, 128'd0, 1'b1, 1, 0, 32'h0, 2'd0};
        tbl[8]  = '{3'd1, 32'h2, 32'd0, 128'h1234, 4'd9, 0, 128'd0, 1'b1, 1, 0, 32'h0, 2'd0};
        tbl[9]  = '{3'd4, 32'h40, 32'd2, 128'd0, 4'd10, 0, 128'd0, 1'b1, 1, 0, 32'h0, 2'd0};
        tbl[10] = '{3'd2, 32'h40, 32'd0, 128'd0, 4'd11, 0,
                    128'h44444444_33333333_22222222_11111111, 1'b0, 3, 1, 32'h10, 2'd0};
        tbl[11] = '{3'd0, 32'h100, 32'd0, 128'd0, 4'd12, 0, 128'd0, 1'b1, 3, 0, 32'h0, 2'd0};
        tbl[12] = '{3'd4, 32'h4C, 32'hFFFFFFFC, 128'd0, 4'd13, 0,
                    128'h11111111_22222222_33333333_44444444, 1'b0, 6, 4, 32'h10, 2'd3};
        tbl[13] = '{3'd0, 32'hFC, 32'd0, 128'd0, 4'd14, 5, 128'hBBBBBBBB, 1'b0, 3, 1, 32'h3C, 2'd3};
        tbl[14] = '{3'd4, 32'hFFFFFFF8, 32'd8, 128'd0, 4'd15, 0, 128'd0, 1'b1, 6, 3, 32'h0, 2'd0};

        for (int i = 0; i < D*4; i++) ref_mem[i] = 32'd0;
        rst = 1'b1; mem_clear = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 32'd0;
        cmd_stride = 32'd0; cmd_wdata = 128'd0; cmd_tag = 4'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        check("reset.rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check("reset.rsp_fields", {rsp_rdata[122:0], rsp_tag, rsp_err}, 128'd0);
        check("reset.mem_req", 128'({mem_req_valid, mem_req_we, mem_req_is_vector,
                                      mem_req_bank_sel, mem_req_addr}), 128'd0);
        check("reset.cmd_ready", 128'(cmd_ready), 128'(1'b1));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            model(tbl[i].op, tbl[i].addr, tbl[i].stride, tbl[i].wdata,
                  m_rd, m_err, m_lat, m_beats, m_fa, m_fb);
            run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].stride,
                    tbl[i].wdata, tbl[i].tag, tbl[i].hold, tbl[i].exp_rdata, tbl[i].exp_err,
                    tbl[i].exp_lat, tbl[i].exp_beats, tbl[i].exp_fa, tbl[i].exp_fb);
        end

        // Randomized commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            m_op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            m_addr = 32'($urandom_range(0, D*16 + 31));
            if ($urandom_range(0, 5) != 0) begin
                if (m_op == 3'd2 || m_op == 3'd3) m_addr[3:0] = 4'd0;
                else m_addr[1:0] = 2'd0;
            end
            case ($urandom_range(0, 4))
                0: m_stride = 32'd4;
                1: m_stride = 32'd16;
                2: m_stride = 32'hFFFFFFFC;
                3: m_stride = 32'd8;
                default: m_stride = 32'($urandom_range(0, 63));
            endcase
            m_wd = {$urandom, $urandom, $urandom, $urandom};
            model(m_op, m_addr, m_stride, m_wd, m_rd, m_err, m_lat, m_beats, m_fa, m_fb);
            run_cmd($sformatf("rnd%0d", i), m_op, m_addr, m_stride, m_wd, 4'($urandom),
                    $urandom_range(0, 2), m_rd, m_err, m_lat, m_beats, m_fa, m_fb);
        end

        // Reset during beat 2 of a strided store.
        m_wd = 128'h0B0B0B0B_0A0A0A0A_09090909_08080808;
        check("rstseq.cmd_ready", 128'(cmd_ready), 128'(1'b1));
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = 32'h80; cmd_stride = 32'd16;
        cmd_wdata = m_wd; cmd_tag = 4'd9; rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("rstseq.beat0", 128'(mem_req_valid), 128'(1'b1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstseq.beat2_valid", 128'(mem_req_valid), 128'(1'b1));
        check("rstseq.beat2_addr", 128'(mem_req_addr), 128'(32'h28));
        rst = 1'b1;
        ref_mem[32] = m_wd[31:0];
        ref_mem[36] = m_wd[63:32];
        ref_mem[40] = m_wd[95:64];
        @(posedge clk); #1;
        check("rstseq.req_after_rst", 128'(mem_req_valid), 128'(1'b0));
        check("rstseq.rsp_after_rst", 128'(rsp_valid), 128'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        seen_req = 1'b0; seen_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen_req |= mem_req_valid;
            seen_rsp |= rsp_valid;
        end
        check("rstseq.no_req", 128'(seen_req), 128'(1'b0));
        check("rstseq.no_rsp", 128'(seen_rsp), 128'(1'b0));
        check("rstseq.ready_after", 128'(cmd_ready), 128'(1'b1));
        rsp_ready = 1'b0;

        model(3'd4, 32'h80, 32'd16, 128'd0, m_rd, m_err, m_lat, m_beats, m_fa, m_fb);
        run_cmd("rstseq.readback", 3'd4, 32'h80, 32'd16, 128'd0, 4'd3, 0,
                m_rd, m_err, m_lat, m_beats, m_fa, m_fb);

        check("mem.out_of_range_requests", 128'(bad_req), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lmem_req_sequencer
`default_nettype wire
